// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one AXI4-Lite word read per instruction and
// hands {pc, snpc} plus the returned instruction word to decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned BUS_W    = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wbu_valid_i,
  input  logic [31:0]      next_pc_i,
  output logic [31:0]      araddr_o,
  output logic             arvalid_o,
  input  logic             arready_i,
  input  logic [31:0]      rdata_i,
  input  logic [1:0]       rresp_i,
  input  logic             rvalid_i,
  output logic             rready_o,
  output logic [BUS_W-1:0] ifu_bdu_bus_o,
  output logic             valid_o,
  output logic [31:0]      inst_rdata_o,
  output logic             inst_rvalid_o,
  output logic             fetch_fault_o,
  output logic [31:0]      fetch_count_o
);

  typedef enum logic [2:0] {StBoot, StIssue, StAr, StRd, StIdle} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending_pc;
  logic        r_pending;
  logic        r_arvalid;
  logic        r_rready;
  logic [31:0] r_fetch_count;

  logic        w_misaligned;
  logic        w_r_beat;
  logic        w_r_ok;

  assign w_misaligned = (r_pc[1:0] != 2'b00);
  // Beats arriving outside RD are stray and never reach decode or the counter.
  assign w_r_beat     = (r_state == StRd) && rvalid_i && !reset;
  assign w_r_ok       = w_r_beat && (rresp_i == 2'b00);

  assign araddr_o      = r_pc;
  assign arvalid_o     = r_arvalid && !reset;
  assign rready_o      = r_rready && !reset;
  assign valid_o       = r_arvalid && arready_i && !reset;
  assign inst_rvalid_o = w_r_ok;
  assign inst_rdata_o  = rdata_i;
  assign fetch_fault_o = ((r_state == StIssue) && w_misaligned && !reset) ||
                         (w_r_beat && (rresp_i != 2'b00));
  assign fetch_count_o = r_fetch_count;
  assign ifu_bdu_bus_o = {r_pc, r_pc + 32'd4};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= StBoot;
      r_pc          <= RESET_PC;
      r_pending_pc  <= 32'd0;
      r_pending     <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_fetch_count <= 32'd0;
    end else begin
      // A retirement seen while busy is remembered; the newest one wins.
      if (wbu_valid_i && (r_state != StIdle)) begin
        r_pending    <= 1'b1;
        r_pending_pc <= next_pc_i;
      end
      case (r_state)
        StBoot: r_state <= StIssue;
        StIssue: begin
          if (w_misaligned) begin
            r_state <= StIdle;
          end else begin
            r_state   <= StAr;
            r_arvalid <= 1'b1;
          end
        end
        StAr: begin
          if (arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StRd;
          end
        end
        StRd: begin
          if (rvalid_i) begin
            r_rready <= 1'b0;
            r_state  <= StIdle;
            if (rresp_i == 2'b00) begin
              r_fetch_count <= r_fetch_count + 32'd1;
            end
          end
        end
        StIdle: begin
          if (wbu_valid_i) begin
            r_pc      <= next_pc_i;
            r_pending <= 1'b0;
            r_state   <= StIssue;
          end else if (r_pending) begin
            r_pc      <= r_pending_pc;
            r_pending <= 1'b0;
            r_state   <= StIssue;
          end
        end
        default: r_state <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a directed vector table, hand-written corner sequences and
// randomized fetches checked against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

  logic        clock;
  logic        reset;
  logic        wbu_valid_i;
  logic [31:0] next_pc_i;
  logic [31:0] araddr_o;
  logic        arvalid_o;
  logic        arready_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rvalid_i;
  logic        rready_o;
  logic [63:0] ifu_bdu_bus_o;
  logic        valid_o;
  logic [31:0] inst_rdata_o;
  logic        inst_rvalid_o;
  logic        fetch_fault_o;
  logic [31:0] fetch_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_fetch #(
    .RESET_PC(32'h8000_0000),
    .BUS_W   (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wbu_valid_i  (wbu_valid_i),
    .next_pc_i    (next_pc_i),
    .araddr_o     (araddr_o),
    .arvalid_o    (arvalid_o),
    .arready_i    (arready_i),
    .rdata_i      (rdata_i),
    .rresp_i      (rresp_i),
    .rvalid_i     (rvalid_i),
    .rready_o     (rready_o),
    .ifu_bdu_bus_o(ifu_bdu_bus_o),
    .valid_o      (valid_o),
    .inst_rdata_o (inst_rdata_o),
    .inst_rvalid_o(inst_rvalid_o),
    .fetch_fault_o(fetch_fault_o),
    .fetch_count_o(fetch_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    bit          misaligned;
    int          ar_stall;
    int          r_stall;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic [31:0] exp_snpc;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    wbu_valid_i = 1'b0;
    arready_i   = 1'b0;
    rvalid_i    = 1'b0;
    rresp_i     = 2'b00;
    rdata_i     = $urandom;
    next_pc_i   = $urandom;
  endtask

  // Holds reset for a few cycles, checks reset values, then releases it on a negedge.
  task automatic reset_dut();
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("rst_arvalid", arvalid_o, 1'b0);
    check("rst_rready", rready_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_fault", fetch_fault_o, 1'b0);
    check("rst_inst_rvalid", inst_rvalid_o, 1'b0);
    check("rst_count", fetch_count_o, 32'd0);
    check("rst_bus_pc", ifu_bdu_bus_o[63:32], 32'h8000_0000);
    reset = 1'b0;
  endtask

  // Drive a retirement in an IDLE cycle.
  task automatic wbu_in_idle(input logic [31:0] pc);
    @(negedge clock);
    clear_inputs();
    wbu_valid_i = 1'b1;
    next_pc_i   = pc;
  endtask

  // Misaligned target: fault pulse in the ISSUE cycle, no bus request, back to IDLE.
  task automatic check_misaligned(input logic [31:0] exp_count);
    @(negedge clock);
    clear_inputs();
    #1;
    check("mis_fault", fetch_fault_o, 1'b1);
    check("mis_arvalid", arvalid_o, 1'b0);
    @(negedge clock);
    clear_inputs();
    #1;
    check("mis_fault_drop", fetch_fault_o, 1'b0);
    check("mis_arvalid_idle", arvalid_o, 1'b0);
    check("mis_count", fetch_count_o, exp_count);
  endtask

  // One full fetch. Optional retirements arrive in the first AR cycle, the first RD cycle and
  // the IDLE cycle that follows the beat. Returns positioned in that IDLE cycle.
  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] exp_snpc,
                          input int exp_wait, input int ar_stall, input int r_stall,
                          input logic [1:0] rresp, input logic [31:0] rdata,
                          input logic [31:0] exp_count,
                          input bit ar_en, input logic [31:0] ar_pc,
                          input bit rd_en, input logic [31:0] rd_pc,
                          input bit idle_en, input logic [31:0] idle_pc);
    int waited = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      clear_inputs();
      #1;
      if (arvalid_o) begin
        waited = i;
        break;
      end
    end
    check("ar_latency", waited, exp_wait);
    if (waited == 0) return;
    for (int k = 0; k <= ar_stall; k++) begin
      if (k > 0) begin
        @(negedge clock);
        clear_inputs();
      end
      if (k == 0 && ar_en) begin
        wbu_valid_i = 1'b1;
        next_pc_i   = ar_pc;
      end
      arready_i = (k == ar_stall);
      #1;
      check("arvalid_held", arvalid_o, 1'b1);
      check("araddr", araddr_o, exp_pc);
      check("valid_pulse", valid_o, arready_i);
    end
    check("bus_pc", ifu_bdu_bus_o[63:32], exp_pc);
    check("bus_snpc", ifu_bdu_bus_o[31:0], exp_snpc);
    for (int k = 0; k <= r_stall; k++) begin
      @(negedge clock);
      clear_inputs();
      if (k == 0 && rd_en) begin
        wbu_valid_i = 1'b1;
        next_pc_i   = rd_pc;
      end
      if (k == r_stall) begin
        rvalid_i = 1'b1;
        rdata_i  = rdata;
        rresp_i  = rresp;
      end
      #1;
      check("arvalid_drop", arvalid_o, 1'b0);
      check("valid_drop", valid_o, 1'b0);
      check("rready", rready_o, 1'b1);
      check("inst_rvalid", inst_rvalid_o, (k == r_stall) && (rresp == 2'b00));
      check("r_fault", fetch_fault_o, (k == r_stall) && (rresp != 2'b00));
      if (k == r_stall && rresp == 2'b00) check("inst_rdata", inst_rdata_o, rdata);
    end
    check("bus_stable", ifu_bdu_bus_o[31:0], exp_snpc);
    @(negedge clock);
    clear_inputs();
    if (idle_en) begin
      wbu_valid_i = 1'b1;
      next_pc_i   = idle_pc;
    end
    #1;
    check("rready_drop", rready_o, 1'b0);
    check("inst_rvalid_idle", inst_rvalid_o, 1'b0);
    check("fault_idle", fetch_fault_o, 1'b0);
    check("count", fetch_count_o, exp_count);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc = $urandom;
    int sel = $urandom_range(0, 9);
    if (sel == 0) pc = 32'hFFFF_FFFC;
    else if (sel > 1) pc[1:0] = 2'b00;
    return pc;
  endfunction

  initial begin
    logic [31:0] m_count;
    logic [31:0] m_next;
    bit          m_have_next;
    logic [31:0] pc;
    bit          ar_en, rd_en, idle_en;
    logic [31:0] ar_pc, rd_pc, idle_pc;
    logic [1:0]  rresp;

    reset = 1'b1;
    clear_inputs();

    //            pc            mis ars rs rresp  rdata          snpc           count
    vecs[0] = '{32'h8000_0000, 0, 2, 3, 2'b00, 32'h0000_0413, 32'h8000_0004, 32'd1};
    vecs[1] = '{32'h8000_0100, 0, 0, 0, 2'b00, 32'h0010_0093, 32'h8000_0104, 32'd2};
    vecs[2] = '{32'h8000_0102, 1, 0, 0, 2'b00, 32'h0000_0000, 32'h8000_0106, 32'd2};
    vecs[3] = '{32'h8000_0010, 0, 1, 1, 2'b10, 32'hDEAD_BEEF, 32'h8000_0014, 32'd2};
    vecs[4] = '{32'hFFFF_FFFC, 0, 0, 2, 2'b00, 32'h1234_5678, 32'h0000_0000, 32'd3};
    vecs[5] = '{32'h0000_0000, 0, 1, 0, 2'b00, 32'h0000_0013, 32'h0000_0004, 32'd4};
    vecs[6] = '{32'h8000_0300, 0, 0, 1, 2'b01, 32'h0BAD_F00D, 32'h8000_0304, 32'd4};

    reset_dut();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) wbu_in_idle(vecs[i].pc);
      if (vecs[i].misaligned) begin
        check_misaligned(vecs[i].exp_count);
      end else begin
        do_fetch(vecs[i].pc, vecs[i].exp_snpc, 2, vecs[i].ar_stall, vecs[i].r_stall,
                 vecs[i].rresp, vecs[i].rdata, vecs[i].exp_count,
                 0, 32'd0, 0, 32'd0, 0, 32'd0);
      end
    end

    // Retirement during RD is replayed without a further wbu_valid_i.
    wbu_in_idle(32'h8000_0040);
    do_fetch(32'h8000_0040, 32'h8000_0044, 2, 0, 1, 2'b00, 32'h1111_1111, 32'd5,
             0, 32'd0, 1, 32'h8000_0200, 0, 32'd0);
    do_fetch(32'h8000_0200, 32'h8000_0204, 2, 0, 0, 2'b00, 32'h2222_2222, 32'd6,
             0, 32'd0, 0, 32'd0, 0, 32'd0);

    // A later pending retirement overwrites an earlier one.
    wbu_in_idle(32'h8000_0800);
    do_fetch(32'h8000_0800, 32'h8000_0804, 2, 1, 1, 2'b00, 32'h3333_3333, 32'd7,
             1, 32'h8000_0400, 1, 32'h8000_0500, 0, 32'd0);
    do_fetch(32'h8000_0500, 32'h8000_0504, 2, 0, 0, 2'b00, 32'h4444_4444, 32'd8,
             0, 32'd0, 0, 32'd0, 0, 32'd0);

    // wbu_valid_i in IDLE beats a pending PC, and the pending PC is then gone.
    wbu_in_idle(32'h8000_0900);
    do_fetch(32'h8000_0900, 32'h8000_0904, 2, 0, 0, 2'b00, 32'h5555_5555, 32'd9,
             0, 32'd0, 1, 32'h8000_0600, 1, 32'h8000_0700);
    do_fetch(32'h8000_0700, 32'h8000_0704, 2, 0, 0, 2'b00, 32'h6666_6666, 32'd10,
             0, 32'd0, 0, 32'd0, 0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      clear_inputs();
      rvalid_i = 1'b1;
      #1;
      check("idle_no_ar", arvalid_o, 1'b0);
      check("stray_rvalid", inst_rvalid_o, 1'b0);
    end
    check("stray_count", fetch_count_o, 32'd10);

    // Reset during RD: a late beat is dropped and fetch restarts from RESET_PC.
    wbu_in_idle(32'h8000_0A00);
    @(negedge clock);
    clear_inputs();
    @(negedge clock);
    clear_inputs();
    arready_i = 1'b1;
    #1;
    check("rd_rst_arvalid", arvalid_o, 1'b1);
    check("rd_rst_valid", valid_o, 1'b1);
    @(negedge clock);
    clear_inputs();
    #1;
    check("rd_rst_rready", rready_o, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    clear_inputs();
    rvalid_i = 1'b1;
    rdata_i  = 32'h0000_0413;
    #1;
    check("rst_beat_drop", inst_rvalid_o, 1'b0);
    check("rst_rready_drop", rready_o, 1'b0);
    check("rst_arvalid_drop", arvalid_o, 1'b0);
    check("rst_count_clr", fetch_count_o, 32'd0);
    @(negedge clock);
    clear_inputs();
    reset    = 1'b0;
    rvalid_i = 1'b1;
    #1;
    check("boot_beat_drop", inst_rvalid_o, 1'b0);
    do_fetch(32'h8000_0000, 32'h8000_0004, 2, 0, 0, 2'b00, 32'h7777_7777, 32'd1,
             0, 32'd0, 0, 32'd0, 0, 32'd0);

    // Randomized fetches against a transaction-level model.
    m_count     = 32'd1;
    m_have_next = 1'b0;
    m_next      = 32'd0;
    for (int n = 0; n < 60; n++) begin
      if (m_have_next) begin
        pc = m_next;
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clock);
          clear_inputs();
          rvalid_i = 1'b1;
          #1;
          check("rand_stray", inst_rvalid_o, 1'b0);
        end
        pc = rand_pc();
        wbu_in_idle(pc);
      end
      m_have_next = 1'b0;
      if (pc[1:0] != 2'b00) begin
        check_misaligned(m_count);
        continue;
      end
      ar_en   = ($urandom_range(0, 4) == 0);
      rd_en   = ($urandom_range(0, 3) == 0);
      idle_en = ($urandom_range(0, 4) == 0);
      ar_pc   = rand_pc();
      rd_pc   = rand_pc();
      idle_pc = rand_pc();
      rresp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (rresp == 2'b00) m_count = m_count + 32'd1;
      do_fetch(pc, pc + 32'd4, 2, $urandom_range(0, 3), $urandom_range(0, 3), rresp, $urandom,
               m_count, ar_en, ar_pc, rd_en, rd_pc, idle_en, idle_pc);
      if (idle_en) begin
        m_have_next = 1'b1;
        m_next      = idle_pc;
      end else if (rd_en) begin
        m_have_next = 1'b1;
        m_next      = rd_pc;
      end else if (ar_en) begin
        m_have_next = 1'b1;
        m_next      = ar_pc;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
